// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - RV32I fetch program-counter generator with redirect, trap and halt control
// The PC, EPC, misalign flag and FSM state are all registered, so pc_o has no combinational input path.
module pc_gen_unit #(
  parameter int unsigned            XLEN         = 32,
  parameter logic [XLEN-1:0]        RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]        TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned            INCR         = 4,
  parameter int unsigned            ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_seq_o,
  output logic            fetch_valid_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] epc_o,
  output logic            halted_o
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misalign_q, misalign_d;
  logic            target_misaligned;
  logic            ctrl_taken;

  assign target_misaligned = (redirect_target_i[ALIGN_BITS-1:0] != '0);
  assign pc_seq_o          = pc_q + XLEN'(INCR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    ctrl_taken = 1'b0;

    // Trap and redirect override stall, handshake and halt in both RUN and HALTED.
    if (state_q != BOOT) begin
      if (trap_i) begin
        pc_d       = TRAP_VECTOR;
        epc_d      = pc_q;
        ctrl_taken = 1'b1;
      end else if (redirect_i && target_misaligned) begin
        pc_d       = TRAP_VECTOR;
        epc_d      = redirect_target_i;
        misalign_d = 1'b1;
        ctrl_taken = 1'b1;
      end else if (redirect_i) begin
        pc_d       = redirect_target_i;
        ctrl_taken = 1'b1;
      end
    end

    case (state_q)
      BOOT: begin
        state_d = halt_i ? HALTED : RUN;
      end
      RUN: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (!ctrl_taken && !stall_i && fetch_ready_i) begin
          pc_d = pc_q + XLEN'(INCR);
        end
      end
      HALTED: begin
        if (resume_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign pc_o          = pc_q;
  assign epc_o         = epc_q;
  assign misalign_o    = misalign_q;
  assign fetch_valid_o = (state_q == RUN);
  assign halted_o      = (state_q == HALTED);

endmodule
